// File: rtl/reg_writeback_queue_pkg.sv
// reg_writeback_queue_pkg: shared widths and the queued writeback entry type
package reg_writeback_queue_pkg;
  localparam int WB_DEPTH = 4;
  localparam int AW = 5;
  localparam int DW = 32;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/reg_writeback_queue_wb_fifo.sv
// wb_fifo: circular entry store with head/tail pointers, occupancy and per-slot valid flags
module wb_fifo
  import reg_writeback_queue_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  wb_entry_t                din_i,
  output wb_entry_t                head_o,
  output wb_entry_t                entries_o [DEPTH],
  output logic [DEPTH-1:0]         valid_o,
  output logic [$clog2(DEPTH)-1:0] head_ptr_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);
  localparam int PW = $clog2(DEPTH);
  wb_entry_t mem_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [PW:0] count_q, count_d;
  assign count_d = count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_q + PW'(pop_i);
      tail_q <= tail_q + PW'(push_i);
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk_i) if (push_i) mem_q[tail_q] <= din_i;
  // a slot is live when its distance from the head is below the occupancy
  for (genvar g = 0; g < DEPTH; g++) begin : g_valid
    assign valid_o[g] = {1'b0, PW'(g) - head_q} < count_q;
  end
  assign head_o = mem_q[head_q];
  assign entries_o = mem_q;
  assign head_ptr_o = head_q;
  assign count_o = count_q;
  assign empty_o = count_q == '0;
  assign full_o = count_q == (PW+1)'(DEPTH);
endmodule

// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: arbitrates ALU/load results into an in-order writeback queue,
// drains one entry per cycle to the register bank and forwards queued values to reads
module reg_writeback_queue
  import reg_writeback_queue_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   alu_valid_i,
  input  logic [AW-1:0]          alu_addr_i,
  input  logic [DW-1:0]          alu_data_i,
  output logic                   alu_ready_o,
  input  logic                   mem_valid_i,
  input  logic [AW-1:0]          mem_addr_i,
  input  logic [DW-1:0]          mem_data_i,
  output logic                   mem_ready_o,
  input  logic                   wb_stall_i,
  output logic                   rgw_o,
  output logic [AW-1:0]          wr_a_o,
  output logic [DW-1:0]          wr_d_o,
  input  logic [AW-1:0]          rd_a_i,
  input  logic [AW-1:0]          rd_b_i,
  output logic                   fwd_a_hit_o,
  output logic [DW-1:0]          fwd_a_data_o,
  output logic                   fwd_b_hit_o,
  output logic [DW-1:0]          fwd_b_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);
  localparam int PW = $clog2(DEPTH);
  wb_entry_t head, din;
  wb_entry_t entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0] head_ptr;
  logic push;
  assign mem_ready_o = !full_o;
  assign alu_ready_o = !full_o && !mem_valid_i;
  assign push = (mem_valid_i && mem_ready_o) || (alu_valid_i && alu_ready_o);
  assign din = mem_valid_i ? {mem_addr_i, mem_data_i} : {alu_addr_i, alu_data_i};
  assign rgw_o = !empty_o && !wb_stall_i;
  assign wr_a_o = empty_o ? '0 : head.addr;
  assign wr_d_o = empty_o ? '0 : head.data;
  // walk oldest to youngest so the last match (closest to the tail) wins
  always_comb begin
    fwd_a_hit_o = 1'b0;
    fwd_a_data_o = '0;
    fwd_b_hit_o = 1'b0;
    fwd_b_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[head_ptr + PW'(i)] && entries[head_ptr + PW'(i)].addr == rd_a_i) begin
        fwd_a_hit_o = 1'b1;
        fwd_a_data_o = entries[head_ptr + PW'(i)].data;
      end
      if (valid[head_ptr + PW'(i)] && entries[head_ptr + PW'(i)].addr == rd_b_i) begin
        fwd_b_hit_o = 1'b1;
        fwd_b_data_o = entries[head_ptr + PW'(i)].data;
      end
    end
  end
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (push),
    .pop_i      (rgw_o),
    .din_i      (din),
    .head_o     (head),
    .entries_o  (entries),
    .valid_o    (valid),
    .head_ptr_o (head_ptr),
    .count_o    (count_o),
    .empty_o    (empty_o),
    .full_o     (full_o)
  );
endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb_reg_writeback_queue: table vectors, corner sequences and a queue-model random run
module tb_reg_writeback_queue;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic alu_valid = 0, mem_valid = 0, wb_stall = 0;
  logic [4:0] alu_addr = 0, mem_addr = 0, rd_a = 0, rd_b = 0;
  logic [31:0] alu_data = 0, mem_data = 0;
  logic alu_ready, mem_ready, rgw, fwd_a_hit, fwd_b_hit, empty, full;
  logic [4:0] wr_a;
  logic [31:0] wr_d, fwd_a_data, fwd_b_data;
  logic [2:0] count;
  int n_chk = 0, n_fail = 0, n_writes = 0;
  logic [31:0] bank [32];
  typedef struct {logic [4:0] a; logic [31:0] d;} ent_t;
  ent_t q[$];
  typedef struct {
    logic mv; logic [4:0] ma; logic [31:0] md;
    logic av; logic [4:0] aa; logic [31:0] ad;
    logic st; logic [4:0] ra;
    logic [2:0] cnt; logic rgw; logic [4:0] wa; logic [31:0] wd;
    logic ardy; logic hit; logic [31:0] fd;
  } vec_t;
  vec_t tbl [12];

  reg_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .alu_valid_i(alu_valid), .alu_addr_i(alu_addr), .alu_data_i(alu_data), .alu_ready_o(alu_ready),
    .mem_valid_i(mem_valid), .mem_addr_i(mem_addr), .mem_data_i(mem_data), .mem_ready_o(mem_ready),
    .wb_stall_i(wb_stall), .rgw_o(rgw), .wr_a_o(wr_a), .wr_d_o(wr_d),
    .rd_a_i(rd_a), .rd_b_i(rd_b),
    .fwd_a_hit_o(fwd_a_hit), .fwd_a_data_o(fwd_a_data),
    .fwd_b_hit_o(fwd_b_hit), .fwd_b_data_o(fwd_b_data),
    .count_o(count), .empty_o(empty), .full_o(full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (rgw) begin
    bank[wr_a] = wr_d;
    n_writes++;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // reference: a FIFO of results; drain the oldest unless stalled, accept one offer if not full
  task automatic model_edge();
    bit was_full = q.size() == DEPTH;
    if (q.size() > 0 && !wb_stall) void'(q.pop_front());
    if (!was_full && mem_valid) q.push_back('{mem_addr, mem_data});
    else if (!was_full && alu_valid) q.push_back('{alu_addr, alu_data});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model();
    logic ha = 0, hb = 0;
    logic [31:0] da = 0, db = 0;
    foreach (q[i]) begin
      if (q[i].a == rd_a) begin ha = 1; da = q[i].d; end
      if (q[i].a == rd_b) begin hb = 1; db = q[i].d; end
    end
    check("count", count, q.size());
    check("empty", empty, q.size() == 0);
    check("full", full, q.size() == DEPTH);
    check("mem_ready", mem_ready, q.size() != DEPTH);
    check("alu_ready", alu_ready, q.size() != DEPTH && !mem_valid);
    check("rgw", rgw, q.size() > 0 && !wb_stall);
    check("wr_a", wr_a, q.size() > 0 ? q[0].a : 5'd0);
    check("wr_d", wr_d, q.size() > 0 ? q[0].d : 32'd0);
    check("fwd_a_hit", fwd_a_hit, ha);
    check("fwd_a_data", fwd_a_data, da);
    check("fwd_b_hit", fwd_b_hit, hb);
    check("fwd_b_data", fwd_b_data, db);
  endtask

  task automatic idle();
    alu_valid = 0; mem_valid = 0;
  endtask

  initial begin
    int w0;
    tbl[0]  = '{0,0,0,     1,7,32'hDEADBEEF,0,7, 0,0,0,0,           1,0,0};
    tbl[1]  = '{0,0,0,     0,0,0,           0,7, 1,1,7,32'hDEADBEEF,1,1,32'hDEADBEEF};
    tbl[2]  = '{1,3,32'h11,1,4,32'h22,      0,0, 0,0,0,0,           0,0,0};
    tbl[3]  = '{0,0,0,     1,4,32'h22,      0,3, 1,1,3,32'h11,      1,1,32'h11};
    tbl[4]  = '{0,0,0,     0,0,0,           0,4, 1,1,4,32'h22,      1,1,32'h22};
    tbl[5]  = '{0,0,0,     0,0,0,           1,4, 0,0,0,0,           1,0,0};
    tbl[6]  = '{0,0,0,     1,5,32'h1,       1,5, 0,0,0,0,           1,0,0};
    tbl[7]  = '{0,0,0,     1,5,32'h2,       1,5, 1,0,5,32'h1,       1,1,32'h1};
    tbl[8]  = '{0,0,0,     0,0,0,           1,5, 2,0,5,32'h1,       1,1,32'h2};
    tbl[9]  = '{0,0,0,     0,0,0,           0,5, 2,1,5,32'h1,       1,1,32'h2};
    tbl[10] = '{0,0,0,     0,0,0,           0,5, 1,1,5,32'h2,       1,1,32'h2};
    tbl[11] = '{0,0,0,     0,0,0,           0,5, 0,0,0,0,           1,0,0};
    rd_b = 6;
    #2;
    check("reset_empty", empty, 1);
    check("reset_rgw", rgw, 0);
    check("reset_ready", mem_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    foreach (tbl[i]) begin
      {mem_valid, mem_addr, mem_data} = {tbl[i].mv, tbl[i].ma, tbl[i].md};
      {alu_valid, alu_addr, alu_data} = {tbl[i].av, tbl[i].aa, tbl[i].ad};
      wb_stall = tbl[i].st; rd_a = tbl[i].ra;
      @(negedge clk);
      check($sformatf("t%0d_count", i), count, tbl[i].cnt);
      check($sformatf("t%0d_rgw", i), rgw, tbl[i].rgw);
      check($sformatf("t%0d_wr_a", i), wr_a, tbl[i].wa);
      check($sformatf("t%0d_wr_d", i), wr_d, tbl[i].wd);
      check($sformatf("t%0d_alu_ready", i), alu_ready, tbl[i].ardy);
      check($sformatf("t%0d_fwd_a_hit", i), fwd_a_hit, tbl[i].hit);
      check($sformatf("t%0d_fwd_a_data", i), fwd_a_data, tbl[i].fd);
      check($sformatf("t%0d_fwd_b_hit", i), fwd_b_hit, 0);
      check($sformatf("t%0d_fwd_b_data", i), fwd_b_data, 0);
      tick();
    end
    check("bank_r7", bank[7], 32'hDEADBEEF);
    check("bank_r3", bank[3], 32'h11);
    check("bank_r4", bank[4], 32'h22);
    check("bank_r5", bank[5], 32'h2);
    // full under stall, then drain one per cycle
    wb_stall = 1; alu_valid = 1;
    for (int k = 0; k < 5; k++) begin
      alu_addr = 5'(10 + k); alu_data = 32'(100 + k);
      @(negedge clk);
      if (k == 4) begin
        check("full_flag", full, 1);
        check("full_alu_ready", alu_ready, 0);
        check("full_mem_ready", mem_ready, 0);
      end
      tick();
    end
    idle(); wb_stall = 0;
    for (int k = 4; k >= 0; k--) begin
      @(negedge clk);
      check("drain_count", count, k);
      check("drain_rgw", rgw, k > 0);
      if (k > 0) check("drain_wr_a", wr_a, 5'(14 - k));
      if (k == 4) check("drain_full_ready", alu_ready, 0);
      if (k == 3) check("drain_ready_back", alu_ready, 1);
      tick();
    end
    // asynchronous reset with entries queued
    wb_stall = 1; alu_valid = 1;
    for (int k = 0; k < 3; k++) begin
      alu_addr = 5'(20 + k); alu_data = 32'(7 + k);
      tick();
    end
    idle(); wb_stall = 0; rd_a = 20;
    #2 rst_n = 0;
    q.delete();
    #1;
    check("rst_count", count, 0);
    check("rst_rgw", rgw, 0);
    check("rst_empty", empty, 1);
    check("rst_fwd", fwd_a_hit, 0);
    @(posedge clk);
    #1 rst_n = 1;
    w0 = n_writes;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_alu_ready", alu_ready, 1);
      tick();
    end
    check("post_rst_no_writes", n_writes, w0);
    // randomized traffic against the queue model, wraps the pointers many times
    for (int c = 0; c < 400; c++) begin
      mem_valid = $urandom_range(0, 2) == 0;
      alu_valid = $urandom_range(0, 1) == 1;
      mem_addr = 5'($urandom_range(0, 7)); mem_data = $urandom;
      alu_addr = 5'($urandom_range(0, 7)); alu_data = $urandom;
      wb_stall = $urandom_range(0, 2) == 0;
      rd_a = 5'($urandom_range(0, 7)); rd_b = 5'($urandom_range(0, 7));
      @(negedge clk);
      check_model();
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
